clock_set_ctrl: RTL
===================

# clock_set_ctrl

Configuration controller for the time-of-day clock. Turns synchronized, debounced button events into one-cycle increment pulses for the seconds, minutes and hours counters. Provides auto-repeat while the increment button is held, an inactivity timeout back to run mode, and a blink mask for the field being edited. Sits between the button synchronizer and the clock counter/seven-segment datapath.

## Interface
- HOLD_CYCLES, 25000000: cycles the increment button must be held after the press before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_CYCLES, 6250000: cycles between auto-repeat pulses (8 Hz).
- BLINK_CYCLES, 12500000: half-period of the edit-field blink.
- TIMEOUT_S, 10: seconds without button activity before SET states return to RUN; range 1..255.
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse once per second from the seconds timer.
- btn_mode  in  1  one-cycle press pulse: enter or leave set mode.
- btn_next  in  1  one-cycle press pulse: select the next field.
- btn_incr  in  1  level, high while the increment button is held (already synchronized).
- run  out  1  high in RUN; the datapath counts on tick_1hz only when run=1.
- inc_sec, inc_min, inc_hour  out  1 each  one-cycle increment pulses; at most one high per cycle.
- field  out  2  0=sec, 1=min, 2=hour, 3=none (RUN).
- blank_mask  out  3  bit0 sec, bit1 min, bit2 hour; 1 blanks that digit pair.

## Operation
- States: RUN, SET_SEC, SET_MIN, SET_HOUR. `field` decodes the state.
- State transitions:
  - btn_mode: RUN→SET_SEC; any SET state→RUN.
  - btn_next: SET_SEC→SET_MIN→SET_HOUR→SET_SEC. Ignored in RUN.
- Priority within one cycle: btn_mode > btn_next > increment activity. A lower-priority event in the same cycle is dropped.
- Increment edge: btn_incr high with the previous sample low, while in a SET state. Produces one inc pulse for the current field and arms the repeat logic.
- Auto-repeat: while armed and btn_incr stays high:
  - first repeat pulse HOLD_CYCLES after the edge;
  - then one pulse every REPEAT_CYCLES.
  - btn_incr low disarms and clears the repeat counter.
  - Any state change disarms; a fresh press is required after it.
- Inc pulses target only the current field. The controller never emits inc_* in RUN.
- Timeout: an 8-bit counter counts tick_1hz in SET states. It clears on:
  - any activity (btn_mode, btn_next, increment edge, repeat pulse);
  - entry to a SET state.
  - Reaching TIMEOUT_S forces RUN. Activity in the same cycle as the expiring tick wins: stay in SET and clear the counter.
- Blink: a phase bit toggles every BLINK_CYCLES in SET states.
  - blank_mask = phase on the current field's bit only.
  - Phase and blink counter reset to 0 (visible) on every activity and every state change.
  - blank_mask = 0 in RUN.
- Counter widths: $clog2 of the largest parameter, plus 1. No wrap-around inside a count window.

## Timing
- All outputs are registered. An event sampled at edge N is reflected at edge N+1.
- Increment edge sampled at N → inc_* high for exactly cycle N+1.
- Repeat pulses at N+1+HOLD_CYCLES, then every REPEAT_CYCLES after.
- Reset (async assert, synchronous release is the integrator's job) sets every output and internal register:
  - state=RUN, run=1, field=3, inc_*=0, blank_mask=0;
  - previous btn_incr sample=0, disarmed, all counters 0.
- Reset mid-repeat or mid-edit leaves no pulse after reset_n asserts.
- btn_incr held across reset release: the edge is seen in RUN and ignored. No repeat.

## Test plan
Parameters for the bench: HOLD_CYCLES=8, REPEAT_CYCLES=4, BLINK_CYCLES=5, TIMEOUT_S=3.
- Reset, then idle 20 cycles -> run=1, field=3, blank_mask=0, no inc_* pulse.
- btn_mode, then btn_next ×3 -> field sequence 0,1,2,0. btn_mode -> run=1, field=3.
- In SET_MIN, btn_incr high for 20 cycles -> inc_min pulses 1 cycle after press, then +8 and +12 cycles later, then every 4 cycles; inc_sec and inc_hour stay 0.
- In SET_SEC, btn_incr rising in the same cycle as btn_next -> no inc pulse, field=1. Holding btn_incr on produces no repeat.
- In SET_HOUR with no activity, 3 tick_1hz pulses -> run=1 the cycle after the 3rd tick. Repeat with btn_next coincident with the 3rd tick -> stays in SET, and 3 more ticks are then required.
- In SET_SEC idle -> blank_mask toggles 000/001 every 5 cycles. A btn_incr press -> mask 000 the next cycle, and the toggle period restarts.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Configuration controller for the time-of-day clock. Converts synchronized,
// debounced button events into one-cycle increment pulses for the seconds,
// minutes and hours counters. It provides auto-repeat while the increment
// button is held, an inactivity timeout back to run mode, and a blink mask for
// the field currently being edited.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   tick_1hz    one-cycle pulse per second (drives the inactivity timeout)
//   btn_mode    press pulse: enter/leave set mode
//   btn_next    press pulse: select the next field (SET states only)
//   btn_incr    level, high while the increment button is held
//   run         high in RUN; the datapath counts only when run=1
//   inc_sec     one-cycle increment pulse for seconds
//   inc_min     one-cycle increment pulse for minutes
//   inc_hour    one-cycle increment pulse for hours
//   field       0=sec, 1=min, 2=hour, 3=none (RUN)
//   blank_mask  bit0 sec, bit1 min, bit2 hour; 1 blanks that digit pair
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 6250000,
  parameter int unsigned BLINK_CYCLES  = 12500000,
  parameter int unsigned TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_incr,
  output logic       run,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic [1:0] field,
  output logic [2:0] blank_mask
);

  // State codes equal the field encoding, so field is the state register itself.
  localparam logic [1:0] ST_SEC  = 2'd0;
  localparam logic [1:0] ST_MIN  = 2'd1;
  localparam logic [1:0] ST_HOUR = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int unsigned MAX_HR = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HR > BLINK_CYCLES) ? MAX_HR : BLINK_CYCLES;
  localparam int unsigned CW = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] HOLD_C     = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REPEAT_C   = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT_S - 1);

  logic [1:0]    state;
  logic          incr_q;     // previous btn_incr sample
  logic          armed;      // auto-repeat enabled by an accepted press
  logic          in_rpt;     // first repeat already issued; now using REPEAT_CYCLES
  logic [CW-1:0] rpt_cnt;    // cycles since the last pulse while armed
  logic [7:0]    to_cnt;     // seconds without activity in SET states
  logic          phase;      // blink phase, 1 = blanked
  logic [CW-1:0] blk_cnt;

  logic [1:0]    state_nxt;
  logic          in_set, state_chg, incr_edge;
  logic          next_ev, incr_ev, rpt_fire, activity, expire;
  logic          phase_nxt;
  logic [CW-1:0] blk_nxt;

  assign field = state;

  assign in_set    = (state != ST_RUN);
  assign incr_edge = btn_incr & ~incr_q;

  // Priority: btn_mode > btn_next > increment activity; lower events drop.
  assign next_ev  = in_set & btn_next & ~btn_mode;
  assign incr_ev  = in_set & incr_edge & ~btn_mode & ~btn_next;
  assign rpt_fire = in_set & armed & btn_incr & ~btn_mode & ~btn_next &
                    (in_rpt ? (rpt_cnt == REPEAT_C) : (rpt_cnt == HOLD_C));
  assign activity = btn_mode | next_ev | incr_ev | rpt_fire;

  // Activity on the expiring tick keeps the controller in SET.
  assign expire = in_set & tick_1hz & (to_cnt == TO_LAST) & ~activity;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (btn_mode) begin
      state_nxt = in_set ? ST_RUN : ST_SEC;
    end else if (next_ev) begin
      case (state)
        ST_SEC:  state_nxt = ST_MIN;
        ST_MIN:  state_nxt = ST_HOUR;
        default: state_nxt = ST_SEC;
      endcase
    end else if (expire) begin
      state_nxt = ST_RUN;
    end
  end

  assign state_chg = (state_nxt != state);

  always_comb begin
    phase_nxt = phase;
    blk_nxt   = blk_cnt;
    if ((state_nxt == ST_RUN) || state_chg || activity) begin
      phase_nxt = 1'b0;
      blk_nxt   = '0;
    end else if (blk_cnt == BLINK_LAST) begin
      phase_nxt = ~phase;
      blk_nxt   = '0;
    end else begin
      blk_nxt   = blk_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      run        <= 1'b1;
      inc_sec    <= 1'b0;
      inc_min    <= 1'b0;
      inc_hour   <= 1'b0;
      blank_mask <= 3'b000;
      incr_q     <= 1'b0;
      armed      <= 1'b0;
      in_rpt     <= 1'b0;
      rpt_cnt    <= '0;
      to_cnt     <= 8'd0;
      phase      <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      state  <= state_nxt;
      run    <= (state_nxt == ST_RUN);
      incr_q <= btn_incr;

      // Pulses never coincide with a state change, so the current field is
      // the target.
      inc_sec  <= (incr_ev | rpt_fire) & (state == ST_SEC);
      inc_min  <= (incr_ev | rpt_fire) & (state == ST_MIN);
      inc_hour <= (incr_ev | rpt_fire) & (state == ST_HOUR);

      // Repeat counter holds "cycles since last pulse"; a fresh press after
      // any state change is required to re-arm.
      if (state_chg || !btn_incr) begin
        armed   <= 1'b0;
        in_rpt  <= 1'b0;
        rpt_cnt <= '0;
      end else if (incr_ev) begin
        armed   <= 1'b1;
        in_rpt  <= 1'b0;
        rpt_cnt <= CW'(1);
      end else if (rpt_fire) begin
        in_rpt  <= 1'b1;
        rpt_cnt <= CW'(1);
      end else if (armed) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end

      if ((state_nxt == ST_RUN) || state_chg || activity) begin
        to_cnt <= 8'd0;
      end else if (tick_1hz) begin
        to_cnt <= to_cnt + 8'd1;
      end

      phase      <= phase_nxt;
      blk_cnt    <= blk_nxt;
      blank_mask <= (state_nxt == ST_RUN) ? 3'b000 : (3'(phase_nxt) << state_nxt);
    end
  end

endmodule
